// File: rtl/fp_wb_arbiter_if.sv
// Bundle of the shared FP register-file write port: per-unit result handshakes
// on one side, the single registered write-port slot on the other.
interface fp_wb_arbiter_if #(
  parameter int NUM_UNITS  = 4,
  parameter int DATA_WIDTH = 34,
  parameter int ID_WIDTH   = 3
);
  localparam int UNIT_W = $clog2(NUM_UNITS);

  logic [NUM_UNITS-1:0]            unit_done;
  logic [NUM_UNITS*ID_WIDTH-1:0]   unit_id;
  logic [NUM_UNITS*DATA_WIDTH-1:0] unit_rd;
  logic [NUM_UNITS-1:0]            unit_ack;
  logic                            wb_valid;
  logic [ID_WIDTH-1:0]             wb_id;
  logic [DATA_WIDTH-1:0]           wb_rd;
  logic                            wb_ready;
  logic [UNIT_W-1:0]               wb_unit;

  modport master (
    input  unit_done, unit_id, unit_rd, wb_ready,
    output unit_ack, wb_valid, wb_id, wb_rd, wb_unit
  );

  modport slave (
    output unit_done, unit_id, unit_rd, wb_ready,
    input  unit_ack, wb_valid, wb_id, wb_rd, wb_unit
  );
endinterface

// File: rtl/fp_wb_arbiter.sv
// Round-robin arbiter merging NUM_UNITS FP unit results into one registered
// write-port slot; a consumed slot is refilled in the same cycle.
module fp_wb_arbiter #(
  parameter int NUM_UNITS  = 4,
  parameter int DATA_WIDTH = 34,
  parameter int ID_WIDTH   = 3
) (
  input logic            clk,
  input logic            rst,
  fp_wb_arbiter_if.master bus
);
  localparam int PW = $clog2(NUM_UNITS);

  logic [PW-1:0]           rr_ptr;
  logic [PW-1:0]           idx;
  logic [PW-1:0]           grant;
  logic                    grant_vld;
  logic                    slot_free;
  logic                    ack_any;
  logic [NUM_UNITS-1:0]    ack_p0;
  logic [ID_WIDTH-1:0]     id_p0;
  logic [DATA_WIDTH-1:0]   rd_p0;

  logic                    vld_p1;
  logic [ID_WIDTH-1:0]     id_p1;
  logic [DATA_WIDTH-1:0]   rd_p1;
  logic [PW-1:0]           unit_p1;

  // Explicit wrap so non-power-of-two unit counts return to 0 after the last unit.
  function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] u);
    if (u == PW'(NUM_UNITS - 1)) return '0;
    else                         return u + 1'b1;
  endfunction

  // Stage p0: pick the first requester at or after rr_ptr, gated by slot availability.
  always_comb begin
    grant_vld = 1'b0;
    grant     = '0;
    idx       = rr_ptr;
    for (int k = 0; k < NUM_UNITS; k++) begin
      if (!grant_vld && bus.unit_done[idx]) begin
        grant_vld = 1'b1;
        grant     = idx;
      end
      idx = wrap_inc(idx);
    end
  end

  assign slot_free = !vld_p1 || bus.wb_ready;
  assign ack_any   = grant_vld && slot_free && !rst;
  assign ack_p0    = ack_any ? (NUM_UNITS'(1) << grant) : '0;
  assign id_p0     = bus.unit_id[int'(grant)*ID_WIDTH +: ID_WIDTH];
  assign rd_p0     = bus.unit_rd[int'(grant)*DATA_WIDTH +: DATA_WIDTH];

  // Stage p1: single output slot; reset also clears the presented payload.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1  <= 1'b0;
      rr_ptr  <= '0;
      id_p1   <= '0;
      rd_p1   <= '0;
      unit_p1 <= '0;
    end else if (ack_any) begin
      vld_p1  <= 1'b1;
      id_p1   <= id_p0;
      rd_p1   <= rd_p0;
      unit_p1 <= grant;
      rr_ptr  <= wrap_inc(grant);
    end else if (slot_free) begin
      vld_p1  <= 1'b0;
    end
  end

  assign bus.unit_ack = ack_p0;
  assign bus.wb_valid = vld_p1;
  assign bus.wb_id    = id_p1;
  assign bus.wb_rd    = rd_p1;
  assign bus.wb_unit  = unit_p1;
endmodule
